exec_core: RTL and testbench

EXEC_CORE -- requirements
Module: exec_core

---
 rtl/exec_core.sv | 127 ++++++++++++
 tb/tb_exec_core.sv | 119 +++++++++++
 2 files changed

// File: rtl/exec_core.sv
// Single-cycle execute core: opcode decode, 32-bit ALU with z/n flags, and a
// 256-word data memory with synchronous write and combinational read.
module exec_core (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  opcode,
   input  logic [31:0] xrs,
   input  logic [31:0] xrt,
   input  logic [31:0] y,
   output logic [2:0]  aluOp,
   output logic        memRead,
   output logic        memWrite,
   output logic        aluSrc,
   output logic [1:0]  writeBackControl,
   output logic        regWrt,
   output logic        branchZero,
   output logic        branchNeg,
   output logic        jump,
   output logic        jumpMem,
   output logic [31:0] aluResult,
   output logic        z,
   output logic        n,
   output logic [31:0] readData
);

   localparam logic [3:0] OP_SVPC = 4'b1111;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_BRN  = 4'b1011;

   logic [31:0] alu_b;
   logic [7:0]  mem_addr;
   logic [31:0] mem [256];

   // Everything defaults to 0 so unlisted opcodes fall through as NOP.
   always_comb begin
      aluOp            = 3'b000;
      memRead          = 1'b0;
      memWrite         = 1'b0;
      aluSrc           = 1'b0;
      writeBackControl = 2'b00;
      regWrt           = 1'b0;
      branchZero       = 1'b0;
      branchNeg        = 1'b0;
      jump             = 1'b0;
      jumpMem          = 1'b0;
      case (opcode)
         OP_SVPC: regWrt = 1'b1;
         OP_LD: begin
            memRead          = 1'b1;
            regWrt           = 1'b1;
            writeBackControl = 2'b01;
         end
         OP_ST: memWrite = 1'b1;
         OP_ADD: begin
            regWrt           = 1'b1;
            writeBackControl = 2'b10;
         end
         OP_INC: begin
            aluSrc           = 1'b1;
            regWrt           = 1'b1;
            writeBackControl = 2'b10;
         end
         OP_NEG: begin
            aluOp            = 3'b010;
            regWrt           = 1'b1;
            writeBackControl = 2'b10;
         end
         OP_SUB: begin
            aluOp            = 3'b001;
            regWrt           = 1'b1;
            writeBackControl = 2'b10;
         end
         OP_J: jump = 1'b1;
         OP_JM: begin
            jump    = 1'b1;
            jumpMem = 1'b1;
            memRead = 1'b1;
         end
         OP_BRZ: begin
            branchZero = 1'b1;
            aluOp      = 3'b011;
         end
         OP_BRN: begin
            branchNeg = 1'b1;
            aluOp     = 3'b011;
         end
         default: ;
      endcase
   end

   assign alu_b = aluSrc ? y : xrt;

   always_comb begin
      case (aluOp)
         3'b000:  aluResult = xrs + alu_b;
         3'b001:  aluResult = xrs - alu_b;
         3'b010:  aluResult = 32'd0 - xrs;
         3'b011:  aluResult = xrs;
         default: aluResult = 32'd0;
      endcase
   end

   assign z = (aluResult == 32'd0);
   assign n = aluResult[31];

   // Only the low byte addresses memory; upper address bits alias.
   assign mem_addr = xrs[7:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      end else if (memWrite) begin
         mem[mem_addr] <= xrt;
      end
   end

   assign readData = memRead ? mem[mem_addr] : 32'd0;

endmodule

// File: tb/tb_exec_core.sv
// Directed-vector bench: stimulus queues hand-computed expectations, a monitor
// pops and compares each vector on the falling edge.
module tb_exec_core;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  opcode = 4'd0;
   logic [31:0] xrs = 32'd0, xrt = 32'd0, y = 32'd0;
   logic [2:0]  aluOp;
   logic        memRead, memWrite, aluSrc, regWrt, branchZero, branchNeg, jump, jumpMem;
   logic [1:0]  writeBackControl;
   logic [31:0] aluResult, readData;
   logic        z, n;

   exec_core dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .xrs(xrs), .xrt(xrt), .y(y),
      .aluOp(aluOp), .memRead(memRead), .memWrite(memWrite), .aluSrc(aluSrc),
      .writeBackControl(writeBackControl), .regWrt(regWrt), .branchZero(branchZero),
      .branchNeg(branchNeg), .jump(jump), .jumpMem(jumpMem),
      .aluResult(aluResult), .z(z), .n(n), .readData(readData)
   );

   always #5 clock = ~clock;

   // ctrl = {aluOp, memRead, memWrite, aluSrc, wb[1:0], regWrt, bz, bn, j, jm}
   typedef struct {
      string       name;
      logic [12:0] ctrl;
      logic [31:0] alu;
      logic        z;
      logic        n;
      logic [31:0] rd;
   } exp_t;

   localparam logic [12:0] C_NOP  = 13'b000_0_0_0_00_0_0_0_0_0;
   localparam logic [12:0] C_SVPC = 13'b000_0_0_0_00_1_0_0_0_0;
   localparam logic [12:0] C_LD   = 13'b000_1_0_0_01_1_0_0_0_0;
   localparam logic [12:0] C_ST   = 13'b000_0_1_0_00_0_0_0_0_0;
   localparam logic [12:0] C_ADD  = 13'b000_0_0_0_10_1_0_0_0_0;
   localparam logic [12:0] C_INC  = 13'b000_0_0_1_10_1_0_0_0_0;
   localparam logic [12:0] C_NEG  = 13'b010_0_0_0_10_1_0_0_0_0;
   localparam logic [12:0] C_SUB  = 13'b001_0_0_0_10_1_0_0_0_0;
   localparam logic [12:0] C_J    = 13'b000_0_0_0_00_0_0_0_1_0;
   localparam logic [12:0] C_JM   = 13'b000_1_0_0_00_0_0_0_1_1;
   localparam logic [12:0] C_BRZ  = 13'b011_0_0_0_00_0_1_0_0_0;
   localparam logic [12:0] C_BRN  = 13'b011_0_0_0_00_0_0_1_0_0;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   function automatic void chk(string vec, string fld, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vec, fld, act, exp);
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "ctrl", {19'd0, aluOp, memRead, memWrite, aluSrc, writeBackControl,
                                 regWrt, branchZero, branchNeg, jump, jumpMem}, {19'd0, e.ctrl});
            chk(e.name, "aluResult", aluResult, e.alu);
            chk(e.name, "z", {31'd0, z}, {31'd0, e.z});
            chk(e.name, "n", {31'd0, n}, {31'd0, e.n});
            chk(e.name, "readData", readData, e.rd);
         end
      end
   end

   task automatic apply(input string nm, input logic rst, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [12:0] c, input logic [31:0] r, input logic ez,
                        input logic en, input logic [31:0] erd);
      exp_t e;
      @(posedge clock);
      #1;
      reset_n = rst;
      opcode = op; xrs = a; xrt = b; y = imm;
      e.name = nm; e.ctrl = c; e.alu = r; e.z = ez; e.n = en; e.rd = erd;
      q.push_back(e);
   endtask

   initial begin : stim
      #1 reset_n = 1'b0;
      apply("ld_in_reset",   0, 4'b1110, 32'h10, 32'h0, 32'h0, C_LD, 32'h10, 0, 0, 32'h0);
      apply("st_in_reset",   0, 4'b0011, 32'h10, 32'h55, 32'h0, C_ST, 32'h65, 0, 0, 32'h0);
      apply("ld_blocked",    1, 4'b1110, 32'h10, 32'h0, 32'h0, C_LD, 32'h10, 0, 0, 32'h0);
      apply("add",           1, 4'b0100, 32'd5, 32'd7, 32'h0, C_ADD, 32'd12, 0, 0, 32'h0);
      apply("sub_zero",      1, 4'b0111, 32'd3, 32'd3, 32'h0, C_SUB, 32'd0, 1, 0, 32'h0);
      apply("neg",           1, 4'b0110, 32'd1, 32'd0, 32'h0, C_NEG, 32'hFFFFFFFF, 0, 1, 32'h0);
      apply("inc_wrap",      1, 4'b0101, 32'hFFFFFFFF, 32'h1234, 32'd1, C_INC, 32'd0, 1, 0, 32'h0);
      apply("st_alias",      1, 4'b0011, 32'h120, 32'hDEADBEEF, 32'h0, C_ST, 32'hDEADC00F, 0, 1, 32'h0);
      apply("ld_alias",      1, 4'b1110, 32'h20, 32'h0, 32'h0, C_LD, 32'h20, 0, 0, 32'hDEADBEEF);
      apply("jm",            1, 4'b1010, 32'h20, 32'h0, 32'h0, C_JM, 32'h20, 0, 0, 32'hDEADBEEF);
      apply("brz",           1, 4'b1001, 32'h0, 32'd9, 32'h0, C_BRZ, 32'h0, 1, 0, 32'h0);
      apply("brn",           1, 4'b1011, 32'h80000000, 32'h0, 32'h0, C_BRN, 32'h80000000, 0, 1, 32'h0);
      apply("j",             1, 4'b1000, 32'h0, 32'h0, 32'h0, C_J, 32'h0, 1, 0, 32'h0);
      apply("svpc",          1, 4'b1111, 32'd2, 32'd3, 32'h0, C_SVPC, 32'd5, 0, 0, 32'h0);
      apply("undef_1101",    1, 4'b1101, 32'h20, 32'h11111111, 32'h0, C_NOP, 32'h11111131, 0, 0, 32'h0);
      apply("nop",           1, 4'b0000, 32'h20, 32'h22222222, 32'h5, C_NOP, 32'h22222242, 0, 0, 32'h0);
      apply("ld_unchanged",  1, 4'b1110, 32'h20, 32'h0, 32'h0, C_LD, 32'h20, 0, 0, 32'hDEADBEEF);
      apply("ld_mid_reset",  0, 4'b1110, 32'h20, 32'h0, 32'h0, C_LD, 32'h20, 0, 0, 32'h0);
      apply("st_after_rst",  1, 4'b0011, 32'h33, 32'hA5A5A5A5, 32'h0, C_ST, 32'hA5A5A5D8, 0, 1, 32'h0);
      apply("ld_after_rst",  1, 4'b1110, 32'h33, 32'h0, 32'h0, C_LD, 32'h33, 0, 0, 32'hA5A5A5A5);
      apply("ld_lost",       1, 4'b1110, 32'h120, 32'h0, 32'h0, C_LD, 32'h120, 0, 0, 32'h0);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clock);
      #1;
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
